// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the memory access arbiter.
//   mem_arb_state_e : controller FSM states (IDLE -> ACCESS -> RESP -> IDLE)
//   mem_req_t       : one latched request (we, addr, wdata) at the default widths
//   DEF_*           : default address/data widths of the attached simple_mem
package mem_arb_pkg;

  localparam int DEF_ADDR_WIDTH = 7;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_NUM_REQ    = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } mem_arb_state_e;

  typedef struct packed {
    logic                      we;
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_DATA_WIDTH-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req       in  : request vector, one bit per requester
//   ptr       in  : index of the highest-priority requester
//   grant     out : one-hot grant, zero when no request
//   grant_idx out : index of the granted requester
//   grant_any out : some requester was granted
// The pointer register lives in the instantiating block.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_any
);

  localparam int unsigned N = NUM_REQ;

  // Scan requesters starting at ptr and wrapping; the first one found wins.
  always_comb begin
    int unsigned cand;
    cand      = 0;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = (32'(ptr) + k) % N;
      if (!grant_any && req[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = IDX_W'(cand);
        grant_any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter: round-robin controller sharing one simple_mem between
// NUM_REQ requesters. One single-beat transaction in flight at a time:
// accept (IDLE) -> memory access (ACCESS) -> response strobe (RESP).
//   clk, rst              : clock, synchronous active-high reset
//   req_valid/ready/we    : per-requester handshake and direction
//   req_addr/req_wdata    : flat per-requester address / write data
//   rsp_valid/rsp_rdata   : one-cycle completion strobe and shared read data
//   mem_addr/cs/we/data   : memory pins; data is tristate, driven only for writes
module mem_access_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REQ    = DEF_NUM_REQ
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ-1:0]           req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [DATA_WIDTH-1:0]        rsp_rdata,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  output logic                         mem_cs,
  output logic                         mem_we,
  inout  wire  [DATA_WIDTH-1:0]        mem_data
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  mem_arb_state_e          state_reg, state_next;
  logic [IDX_W-1:0]        ptr_reg;
  logic [IDX_W-1:0]        gidx_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic                    we_reg;
  logic [DATA_WIDTH-1:0]   wdata_reg;
  logic [DATA_WIDTH-1:0]   rdata_reg;

  logic [NUM_REQ-1:0]      grant;
  logic [IDX_W-1:0]        grant_idx;
  logic                    grant_any;
  logic                    accept;
  logic                    data_oe;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (ptr_reg),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign accept = (state_reg == IDLE) && grant_any;

  // ---------------- state register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant_any) state_next = ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg   <= '0;
      gidx_reg  <= '0;
      addr_reg  <= '0;
      we_reg    <= 1'b0;
      wdata_reg <= '0;
      rdata_reg <= '0;
    end else begin
      if (accept) begin
        gidx_reg  <= grant_idx;
        addr_reg  <= req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
        we_reg    <= req_we[grant_idx];
        wdata_reg <= req_wdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
        // The winner drops to lowest priority.
        ptr_reg   <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end
      // Captured at the end of ACCESS so the new value appears exactly in RESP;
      // writes report zero.
      if (state_reg == ACCESS) begin
        rdata_reg <= we_reg ? '0 : mem_data;
      end
    end
  end

  // ---------------- outputs ----------------
  always_comb begin
    req_ready = '0;
    mem_cs    = 1'b0;
    mem_we    = 1'b0;
    data_oe   = 1'b0;
    case (state_reg)
      IDLE:    req_ready = grant;
      ACCESS: begin
        mem_cs  = 1'b1;
        mem_we  = we_reg;
        data_oe = we_reg;
      end
      default: ;
    endcase
  end

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
      assign rsp_valid[gi] = (state_reg == RESP) && (gidx_reg == IDX_W'(gi));
    end
  endgenerate

  // mem_addr simply follows the latched address, so it holds while cs is low.
  assign mem_addr  = addr_reg;
  assign rsp_rdata = rdata_reg;
  assign mem_data  = data_oe ? wdata_reg : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_mem_access_arbiter.sv
module tb_mem_access_arbiter;

  localparam int AW = 7;
  localparam int DW = 8;
  localparam int NR = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     req_we = '0;
  logic [NR*AW-1:0]  req_addr = '0;
  logic [NR*DW-1:0]  req_wdata = '0;
  logic [NR-1:0]     rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic [AW-1:0]     mem_addr;
  logic              mem_cs;
  logic              mem_we;
  wire  [DW-1:0]     mem_data;

  int tests_run = 0;
  int tests_failed = 0;
  logic mon_en = 1'b0;
  logic mem_init = 1'b0;

  always #5 clk = ~clk;

  mem_access_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_REQ    (NR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .mem_addr  (mem_addr),
    .mem_cs    (mem_cs),
    .mem_we    (mem_we),
    .mem_data  (mem_data)
  );

  // simple_mem model: async read while selected for read, write on the edge.
  logic [DW-1:0] mem_arr [0:127];
  assign mem_data = (mem_cs && !mem_we) ? mem_arr[mem_addr] : {DW{1'bz}};
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 128; i++) mem_arr[i] <= 8'(i) + 8'h30;
    end else if (mem_cs && mem_we) begin
      mem_arr[mem_addr] <= mem_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Controller may drive the bus only during a write access.
  always @(negedge clk) begin
    #2;
    if (mon_en) check("bus_oe", 32'(dut.data_oe), 32'(mem_cs & mem_we));
  end

  task automatic do_req(input int r, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [DW-1:0] exp_rd, input string tag);
    int waited;
    @(negedge clk);
    req_valid[r] = 1'b1;
    req_we[r] = we;
    req_addr[r*AW +: AW] = a;
    req_wdata[r*DW +: DW] = d;
    waited = 0;
    #1;
    while (req_ready == '0 && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    check({tag, "_ready"}, 32'(req_ready), 32'(1 << r));
    @(negedge clk);
    req_valid[r] = 1'b0;
    #1;
    check({tag, "_acc_norsp"}, 32'(rsp_valid), 32'(0));
    check({tag, "_acc_cs"}, 32'(mem_cs), 32'(1));
    @(negedge clk);
    #1;
    check({tag, "_rsp"}, 32'(rsp_valid), 32'(1 << r));
    check({tag, "_rdata"}, 32'(rsp_rdata), 32'(we ? 8'h00 : exp_rd));
    check({tag, "_rsp_cs"}, 32'(mem_cs), 32'(0));
    $display("[TB] %s req%0d we=%0d addr=0x%02h wdata=0x%02h rdata=0x%02h", tag, r, we, a, d, rsp_rdata);
  endtask

  logic [NR-1:0] exp_rdy, exp_rsp;
  int idx;

  initial begin
    mem_init = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    mem_init = 1'b0;
    rst = 1'b0;
    #1;
    check("rst_ready", 32'(req_ready), 32'(0));
    check("rst_rsp", 32'(rsp_valid), 32'(0));
    check("rst_rdata", 32'(rsp_rdata), 32'(0));
    check("rst_cs", 32'(mem_cs), 32'(0));
    check("rst_we", 32'(mem_we), 32'(0));
    check("rst_addr", 32'(mem_addr), 32'(0));
    mon_en = 1'b1;

    // Write then read, one requester.
    do_req(0, 1'b1, 7'h05, 8'hA5, 8'h00, "wr05");
    do_req(0, 1'b0, 7'h05, 8'h00, 8'hA5, "rd05");

    // Boundary address; addr 0 keeps its preload.
    do_req(1, 1'b1, 7'h7F, 8'hFF, 8'h00, "wr7f");
    do_req(0, 1'b0, 7'h7F, 8'h00, 8'hFF, "rd7f");
    do_req(1, 1'b0, 7'h00, 8'h00, 8'h30, "rd00");

    // Contention right after reset: grants alternate 0,1,0,1 every 3 cycles.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req_valid = 2'b11;
    req_we = 2'b00;
    req_addr[0 +: AW] = 7'h10;
    req_addr[AW +: AW] = 7'h20;
    for (int k = 0; k < 12; k++) begin
      #1;
      exp_rdy = (k % 3 == 0) ? NR'(1 << ((k / 3) % 2)) : '0;
      exp_rsp = (k % 3 == 2) ? NR'(1 << ((k / 3) % 2)) : '0;
      check("cont_ready", 32'(req_ready), 32'(exp_rdy));
      check("cont_rsp", 32'(rsp_valid), 32'(exp_rsp));
      if (exp_rsp != '0) begin
        check("cont_rdata", 32'(rsp_rdata), 32'(((k / 3) % 2 == 0) ? 8'h40 : 8'h50));
        $display("[TB] cont cycle %0d rsp=%b rdata=0x%02h", k, rsp_valid, rsp_rdata);
      end
      @(negedge clk);
    end
    req_valid = '0;

    // Single active requester: four back-to-back writes from req1.
    idx = 0;
    for (int k = 0; k < 12; k++) begin
      req_valid[1] = (idx < 4);
      req_we[1] = 1'b1;
      req_addr[AW +: AW] = AW'(idx);
      req_wdata[DW +: DW] = 8'hC0 + 8'(idx);
      #1;
      exp_rdy = (k % 3 == 0) ? 2'b10 : 2'b00;
      exp_rsp = (k % 3 == 2) ? 2'b10 : 2'b00;
      check("single_ready", 32'(req_ready), 32'(exp_rdy));
      check("single_rsp", 32'(rsp_valid), 32'(exp_rsp));
      if (exp_rsp != '0) begin
        check("single_wr_rdata", 32'(rsp_rdata), 32'(0));
        $display("[TB] single write cycle %0d rsp=%b", k, rsp_valid);
      end
      if (req_ready[1]) idx++;
      @(negedge clk);
    end
    req_valid = '0;
    for (int i = 0; i < 4; i++) begin
      do_req(1, 1'b0, AW'(i), 8'h00, 8'hC0 + 8'(i), "single_rd");
    end

    // Reset during the ACCESS cycle of a read from req0.
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_we[0] = 1'b0;
    req_addr[0 +: AW] = 7'h05;
    #1;
    check("mid_ready", 32'(req_ready), 32'(1));
    @(negedge clk);
    req_valid[0] = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_in_access", 32'(mem_cs), 32'(1));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rsp", 32'(rsp_valid), 32'(0));
    check("mid_cs", 32'(mem_cs), 32'(0));
    check("mid_we", 32'(mem_we), 32'(0));
    check("mid_addr", 32'(mem_addr), 32'(0));
    check("mid_rdata", 32'(rsp_rdata), 32'(0));
    check("mid_ready0", 32'(req_ready), 32'(0));
    check("mid_ptr", 32'(dut.ptr_reg), 32'(0));
    $display("[TB] mid-transaction reset applied");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check("mid_no_rsp", 32'(rsp_valid), 32'(0));
    end
    do_req(1, 1'b0, 7'h05, 8'h00, 8'hA5, "post_rst_rd");

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
